// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction prefetch queue feeding the IF/ID register
module fetch_queue #(
   parameter int          DEPTH    = 4,
   parameter logic [63:0] RESET_PC = 64'd0,
   parameter int          ADDR_W   = 64,
   parameter int          INSTR_W  = 32
) (
   input  logic                       clk,
   input  logic                       reset,
   output logic                       imem_req,
   output logic [ADDR_W-1:0]          imem_addr,
   input  logic                       imem_rvalid,
   input  logic [INSTR_W-1:0]         imem_rdata,
   input  logic                       redirect,
   input  logic [ADDR_W-1:0]          redirect_pc,
   output logic                       out_valid,
   output logic [INSTR_W-1:0]         out_instr,
   output logic [ADDR_W-1:0]          out_pc,
   input  logic                       out_ready,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH+1);

   // started_q holds off the first request until a clock edge has been seen out of reset
   logic               started_q, started_d;
   logic               inflight_q, inflight_d;
   logic               drop_q, drop_d;
   logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
   logic [ADDR_W-1:0]  req_pc_q, req_pc_d;
   logic [PW-1:0]      head_q, head_d;
   logic [PW-1:0]      tail_q, tail_d;
   logic [CW-1:0]      count_q, count_d;
   logic [INSTR_W-1:0] instr_mem_q [DEPTH];
   logic [INSTR_W-1:0] instr_mem_d [DEPTH];
   logic [ADDR_W-1:0]  pc_mem_q [DEPTH];
   logic [ADDR_W-1:0]  pc_mem_d [DEPTH];

   logic [CW:0]        credit_used;
   logic               wr_en;
   logic               pop;

   // Request issue uses registered occupancy plus the outstanding request only
   always_comb begin
      credit_used = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
      imem_req    = started_q && (credit_used < (CW+1)'(DEPTH));
      imem_addr   = fetch_pc_q;
      out_valid   = (count_q != '0);
      out_instr   = instr_mem_q[head_q];
      out_pc      = pc_mem_q[head_q];
      count       = count_q;
      wr_en       = imem_rvalid && inflight_q && !drop_q && !redirect;
      pop         = out_valid && out_ready;
   end

   // Next-state: redirect flushes everything, otherwise capture responses and pop the head
   always_comb begin
      started_d   = 1'b1;
      inflight_d  = imem_req;
      drop_d      = 1'b0;
      fetch_pc_d  = fetch_pc_q;
      req_pc_d    = imem_req ? fetch_pc_q : req_pc_q;
      head_d      = head_q;
      tail_d      = tail_q;
      count_d     = count_q;
      instr_mem_d = instr_mem_q;
      pc_mem_d    = pc_mem_q;

      if (redirect) begin
         // The request issued this cycle returns next cycle for the old path
         drop_d     = imem_req;
         fetch_pc_d = redirect_pc;
         head_d     = '0;
         tail_d     = '0;
         count_d    = '0;
      end else begin
         if (imem_req) begin
            fetch_pc_d = fetch_pc_q + ADDR_W'(4);
         end
         if (wr_en) begin
            instr_mem_d[tail_q] = imem_rdata;
            pc_mem_d[tail_q]    = req_pc_q;
            tail_d              = tail_q + PW'(1);
         end
         if (pop) begin
            head_d = head_q + PW'(1);
         end
         case ({wr_en, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // State registers, cleared asynchronously by reset
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         started_q   <= 1'b0;
         inflight_q  <= 1'b0;
         drop_q      <= 1'b0;
         fetch_pc_q  <= RESET_PC[ADDR_W-1:0];
         req_pc_q    <= '0;
         head_q      <= '0;
         tail_q      <= '0;
         count_q     <= '0;
         instr_mem_q <= '{default: '0};
         pc_mem_q    <= '{default: '0};
      end else begin
         started_q   <= started_d;
         inflight_q  <= inflight_d;
         drop_q      <= drop_d;
         fetch_pc_q  <= fetch_pc_d;
         req_pc_q    <= req_pc_d;
         head_q      <= head_d;
         tail_q      <= tail_d;
         count_q     <= count_d;
         instr_mem_q <= instr_mem_d;
         pc_mem_q    <= pc_mem_d;
      end
   end

   // Credit accounting must never let a response land in a full queue
   a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
      !(wr_en && (count_q == CW'(DEPTH))));

endmodule
